// File: rtl/pd_gpio_edge_irq_if.sv
// Avalon-MM slave bus bundle for the pd_gpio_edge_irq register file.
interface pd_gpio_edge_irq_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pd_gpio_edge_irq.sv
// GPIO port with set/clear output aliases, direction register, synchronised and
// optionally debounced inputs, per-bit rise/fall edge capture and a masked irq.

// Per-channel input path: synchroniser, optional debounce, edge detect.
module pd_gpio_edge_irq_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_bit,
    output logic filt,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   filt_d;

    // Shift chain; sync[0] takes the raw pin, the last stage feeds the filter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], in_bit};
    end

    assign s = sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_nodb
            // Filter bypassed: filt simply follows the synchronised input.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) filt <= 1'b0;
                else       filt <= s;
            end
        end else begin : g_db
            localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
            logic [15:0] cnt;

            // filt only follows s after s has disagreed for N consecutive edges.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    filt <= 1'b0;
                    cnt  <= '0;
                end else if (s == filt) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    filt <= s;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end
        end
    endgenerate

    // One-cycle delayed copy of filt for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) filt_d <= 1'b0;
        else       filt_d <= filt;
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;
endmodule

module pd_gpio_edge_irq #(
    parameter int               WIDTH           = 32,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 0,
    parameter logic [WIDTH-1:0] RESET_OUT       = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    pd_gpio_edge_irq_if.slave    bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic [WIDTH-1:0]     out_port,
    output logic [WIDTH-1:0]     out_oe,
    output logic                 irq
);
    localparam logic [2:0] A_DATA = 3'd0, A_DIR  = 3'd1, A_MASK = 3'd2, A_CAP  = 3'd3,
                           A_SET  = 3'd4, A_CLR  = 3'd5, A_RISE = 3'd6, A_FALL = 3'd7;

    logic [WIDTH-1:0] data_out, dir, irq_mask, edge_capture, rise_en, fall_en;
    logic [WIDTH-1:0] filt, rise, fall, events, wd, rd_mux;
    logic             wr;

    pd_gpio_edge_irq_bit #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit [WIDTH-1:0] (
        .clk    (clk),
        .reset  (reset),
        .in_bit (in_port),
        .filt   (filt),
        .rise   (rise),
        .fall   (fall)
    );

    assign wr     = bus.chipselect & ~bus.write_n;
    assign wd     = bus.writedata[WIDTH-1:0];
    assign events = (rise & rise_en) | (fall & fall_en);

    // Control registers; OUTSET/OUTCLR are read-modify-write aliases of data_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= RESET_OUT;
            dir      <= '0;
            irq_mask <= '0;
            rise_en  <= '0;
            fall_en  <= '1;
        end else if (wr) begin
            case (bus.address)
                A_DATA:  data_out <= wd;
                A_DIR:   dir      <= wd;
                A_MASK:  irq_mask <= wd;
                A_SET:   data_out <= data_out | wd;
                A_CLR:   data_out <= data_out & ~wd;
                A_RISE:  rise_en  <= wd;
                A_FALL:  fall_en  <= wd;
                default: ;
            endcase
        end
    end

    // Sticky flags: W1C is applied first so a simultaneous new edge survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~((wr && bus.address == A_CAP) ? wd : '0)) | events;
        end
    end

    // Read mux on pre-write register state.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            A_DATA:  rd_mux = filt;
            A_DIR:   rd_mux = dir;
            A_MASK:  rd_mux = irq_mask;
            A_CAP:   rd_mux = edge_capture;
            A_RISE:  rd_mux = rise_en;
            A_FALL:  rd_mux = fall_en;
            default: rd_mux = '0;
        endcase
    end

    // Registered read data, updated every cycle regardless of chipselect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= 32'(rd_mux);
    end

    assign out_port = data_out;
    assign out_oe   = dir;
    assign irq      = |(edge_capture & irq_mask);
endmodule
